// File: rtl/rv_stage_seq_pkg.sv
// Shared definitions for the multicycle RV stage sequencer.
// Contents:
//   stage_e       - stage codes seen on o_stage (FETCH=1 .. WRITE=5, HALT=7)
//   DONE_*        - bit positions inside the one-hot o_stage_done vector
//   *_DEF         - default slave-select field and TCM select value
//   wb_req_t      - one Wishbone request beat {adr, dat, sel, we}
package rv_stage_seq_pkg;

  typedef enum logic [2:0] {
    STAGE_FETCH   = 3'd1,
    STAGE_DECODE  = 3'd2,
    STAGE_EXECUTE = 3'd3,
    STAGE_MEMORY  = 3'd4,
    STAGE_WRITE   = 3'd5,
    STAGE_HALT    = 3'd7
  } stage_e;

  localparam int DONE_F = 0;
  localparam int DONE_D = 1;
  localparam int DONE_E = 2;
  localparam int DONE_M = 3;
  localparam int DONE_W = 4;

  localparam int         SEL_HI_DEF  = 31;
  localparam int         SEL_LO_DEF  = 28;
  localparam logic [3:0] TCM_SEL_DEF = 4'h0;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wb_req_t;

endpackage

// File: rtl/rv_stage_seq_wb.sv
// Single-beat Wishbone request/terminate engine with bus timeout.
// Ports:
//   i_clk, i_reset_n  clock, synchronous active-low reset
//   i_start           latch i_req; cyc/stb rise on the following cycle
//   i_req             request beat to register
//   i_ack, i_err      slave termination inputs
//   o_req             registered request, held stable until termination
//   o_cyc, o_stb      bus cycle / strobe
//   o_done            clean ACK termination this cycle
//   o_fault           ERR, or timeout expiry without ACK, this cycle
module rv_stage_seq_wb
  import rv_stage_seq_pkg::*;
#(
  parameter int WB_TIMEOUT = 255
) (
  input  logic    i_clk,
  input  logic    i_reset_n,
  input  logic    i_start,
  input  wb_req_t i_req,
  input  logic    i_ack,
  input  logic    i_err,
  output wb_req_t o_req,
  output logic    o_cyc,
  output logic    o_stb,
  output logic    o_done,
  output logic    o_fault
);

  localparam int CNT_W = (WB_TIMEOUT > 0) ? $clog2(WB_TIMEOUT + 1) : 1;
  localparam int LAST  = (WB_TIMEOUT > 0) ? WB_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

  logic             cyc_q, cyc_d;
  wb_req_t          req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire;

  // The counter holds the number of cyc-high cycles already elapsed, so the
  // cycle where it equals WB_TIMEOUT-1 is the last one allowed; an ACK there
  // still wins, and ERR always beats ACK.
  always_comb begin
    o_done  = cyc_q && i_ack && !i_err;
    expire  = (WB_TIMEOUT != 0) && cyc_q && !i_ack && !i_err && (cnt_q >= LAST_CNT);
    o_fault = (cyc_q && i_err) || expire;
    req_d   = req_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    if (i_start) begin
      req_d = i_req;
      cyc_d = 1'b1;
      cnt_d = '0;
    end else if (o_done || o_fault) begin
      cyc_d = 1'b0;
    end else if (cyc_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cyc_q <= 1'b0;
      req_q <= '0;
      cnt_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      req_q <= req_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_req = req_q;
  assign o_cyc = cyc_q;
  assign o_stb = cyc_q;

endmodule

// File: rtl/rv_stage_seq.sv
// Stage sequencer and Wishbone master for the multicycle RV core.
// Steps FETCH->DECODE->EXECUTE->MEMORY->WRITE; external fetches and
// loads/stores wait on the bus, TCM accesses take one cycle. A bus error or
// timeout latches the faulting address and parks the sequencer in HALT.
// Ports:
//   i_clk, i_reset_n            clock, synchronous active-low reset
//   i_pc                        fetch PC[31:2]
//   i_mem_read/i_mem_write      MEMORY-stage load/store request
//   i_addr/i_wdata/i_sel        MEMORY-stage address, store data, byte lanes
//   o_wb_* / i_wb_*             classic single-beat Wishbone master
//   o_stage, o_stage_done       current stage code, one-hot stage completion
//   o_tcm_data_sel              MEMORY access targets the TCM
//   o_inst, o_inst_wb           instruction fetched over WB and its valid flag
//   o_rdata                     load data captured from WB
//   o_halted, o_fault_addr      fault status
module rv_stage_seq
  import rv_stage_seq_pkg::*;
#(
  parameter int                   TCM_ADDR_WIDTH = 12,
  parameter int                   SEL_HI         = SEL_HI_DEF,
  parameter int                   SEL_LO         = SEL_LO_DEF,
  parameter logic [SEL_HI-SEL_LO:0] TCM_SEL      = TCM_SEL_DEF,
  parameter int                   FETCH_WB       = 0,
  parameter int                   WB_TIMEOUT     = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [29:0] i_pc,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_sel,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic [2:0]  o_stage,
  output logic [4:0]  o_stage_done,
  output logic        o_tcm_data_sel,
  output logic [31:0] o_inst,
  output logic        o_inst_wb,
  output logic [31:0] o_rdata,
  output logic        o_halted,
  output logic [31:0] o_fault_addr
);

  // The TCM word space must sit entirely below the slave-select field.
  if ((TCM_ADDR_WIDTH + 2 > SEL_LO) || (SEL_HI > 31) || (SEL_HI < SEL_LO)) begin : g_bad_cfg
    $error("rv_stage_seq: TCM range overlaps the slave-select field");
  end

  stage_e      stage_q, stage_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_wb_q, inst_wb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        halted_q, halted_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic        wb_start, wb_cyc, wb_stb, wb_done, wb_fault;
  wb_req_t     wb_req_next, wb_req;
  logic [31:0] pc_byte;
  logic        pc_tcm, addr_tcm, fetch_wb, mem_access;

  assign pc_byte    = {i_pc, 2'b00};
  assign pc_tcm     = (pc_byte[SEL_HI:SEL_LO] == TCM_SEL);
  assign addr_tcm   = (i_addr[SEL_HI:SEL_LO] == TCM_SEL);
  assign fetch_wb   = (FETCH_WB != 0) && !pc_tcm;
  assign mem_access = i_mem_read || i_mem_write;

  rv_stage_seq_wb #(.WB_TIMEOUT(WB_TIMEOUT)) u_wb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (wb_start),
    .i_req     (wb_req_next),
    .i_ack     (i_wb_ack),
    .i_err     (i_wb_err),
    .o_req     (wb_req),
    .o_cyc     (wb_cyc),
    .o_stb     (wb_stb),
    .o_done    (wb_done),
    .o_fault   (wb_fault)
  );

  // A WB phase spends its first cycle launching the request (cyc still low)
  // and then waits while cyc is high; a fault overrides whatever the stage
  // would otherwise do. Store-with-read is issued as a write.
  always_comb begin
    stage_d      = stage_q;
    o_stage_done = '0;
    wb_start     = 1'b0;
    wb_req_next  = '0;
    inst_d       = inst_q;
    inst_wb_d    = inst_wb_q;
    rdata_d      = rdata_q;
    halted_d     = halted_q;
    fault_addr_d = fault_addr_q;
    case (stage_q)
      STAGE_FETCH: begin
        if (wb_cyc) begin
          if (wb_done) begin
            o_stage_done[DONE_F] = 1'b1;
            stage_d              = STAGE_DECODE;
            inst_d               = i_wb_dat;
            inst_wb_d            = 1'b1;
          end
        end else if (fetch_wb) begin
          wb_start        = 1'b1;
          wb_req_next.adr = pc_byte;
          wb_req_next.sel = 4'hF;
          wb_req_next.we  = 1'b0;
        end else begin
          o_stage_done[DONE_F] = 1'b1;
          stage_d              = STAGE_DECODE;
          inst_wb_d            = 1'b0;
        end
      end
      STAGE_DECODE: begin
        o_stage_done[DONE_D] = 1'b1;
        stage_d              = STAGE_EXECUTE;
      end
      STAGE_EXECUTE: begin
        o_stage_done[DONE_E] = 1'b1;
        stage_d              = STAGE_MEMORY;
      end
      STAGE_MEMORY: begin
        if (wb_cyc) begin
          if (wb_done) begin
            o_stage_done[DONE_M] = 1'b1;
            stage_d              = STAGE_WRITE;
            if (!wb_req.we) begin
              rdata_d = i_wb_dat;
            end
          end
        end else if (mem_access && !addr_tcm) begin
          wb_start        = 1'b1;
          wb_req_next.adr = i_addr;
          wb_req_next.dat = i_wdata;
          wb_req_next.sel = i_sel;
          wb_req_next.we  = i_mem_write;
        end else begin
          o_stage_done[DONE_M] = 1'b1;
          stage_d              = STAGE_WRITE;
        end
      end
      STAGE_WRITE: begin
        o_stage_done[DONE_W] = 1'b1;
        stage_d              = STAGE_FETCH;
      end
      STAGE_HALT: begin
        stage_d = STAGE_HALT;
      end
      default: begin
        stage_d = STAGE_WRITE;
      end
    endcase
    if (wb_fault) begin
      stage_d      = STAGE_HALT;
      halted_d     = 1'b1;
      fault_addr_d = wb_req.adr;
    end
    // The datapath must not load anything while reset is held.
    if (!i_reset_n) begin
      o_stage_done = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      stage_q      <= STAGE_WRITE;
      inst_q       <= '0;
      inst_wb_q    <= 1'b0;
      rdata_q      <= '0;
      halted_q     <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      stage_q      <= stage_d;
      inst_q       <= inst_d;
      inst_wb_q    <= inst_wb_d;
      rdata_q      <= rdata_d;
      halted_q     <= halted_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign o_stage        = stage_q;
  assign o_tcm_data_sel = (stage_q == STAGE_MEMORY) && mem_access && addr_tcm;
  assign o_wb_adr       = wb_req.adr;
  assign o_wb_dat       = wb_req.dat;
  assign o_wb_sel       = wb_req.sel;
  assign o_wb_we        = wb_req.we;
  assign o_wb_cyc       = wb_cyc;
  assign o_wb_stb       = wb_stb;
  assign o_inst         = inst_q;
  assign o_inst_wb      = inst_wb_q;
  assign o_rdata        = rdata_q;
  assign o_halted       = halted_q;
  assign o_fault_addr   = fault_addr_q;

endmodule

// File: tb/tb_rv_stage_seq.sv
// Self-checking bench for rv_stage_seq (FETCH_WB=1, WB_TIMEOUT=4, TCM = top
// nibble 0). Each instruction is expanded into a per-cycle expectation list
// from stage durations: 1 cycle for TCM/no access, N cycles for a WB phase
// whose ACK arrives on phase cycle N (cycle 1 launches the request).
module tb_rv_stage_seq;

  localparam int TB_TIMEOUT = 4;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [29:0] i_pc;
  logic        i_mem_read, i_mem_write;
  logic [31:0] i_addr, i_wdata, i_wb_dat;
  logic [3:0]  i_sel;
  logic        i_wb_ack, i_wb_err;
  logic [31:0] o_wb_adr, o_wb_dat, o_inst, o_rdata, o_fault_addr;
  logic        o_wb_we, o_wb_stb, o_wb_cyc, o_tcm_data_sel, o_inst_wb, o_halted;
  logic [3:0]  o_wb_sel;
  logic [2:0]  o_stage;
  logic [4:0]  o_stage_done;

  always #5 i_clk = ~i_clk;

  rv_stage_seq #(
    .TCM_ADDR_WIDTH(12), .SEL_HI(31), .SEL_LO(28), .TCM_SEL(4'h0),
    .FETCH_WB(1), .WB_TIMEOUT(TB_TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_pc(i_pc),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_sel(i_sel),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat),
    .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel), .o_wb_stb(o_wb_stb),
    .o_wb_cyc(o_wb_cyc), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_stage(o_stage), .o_stage_done(o_stage_done),
    .o_tcm_data_sel(o_tcm_data_sel), .o_inst(o_inst), .o_inst_wb(o_inst_wb),
    .o_rdata(o_rdata), .o_halted(o_halted), .o_fault_addr(o_fault_addr)
  );

  typedef struct packed {
    logic [2:0]  stage;
    logic [4:0]  done;
    logic        cyc;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        tsel;
    logic        halt;
  } rec_t;

  rec_t        plan[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_inst, exp_rdata, exp_fault;
  logic        exp_inst_wb, exp_halted;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s t=%0t observed=0x%08h expected=0x%08h", tag, $time, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic [2:0] st, input logic [4:0] dn);
    rec_t r;
    r      = '0;
    r.stage = st;
    r.done  = dn;
    r.rdat  = $urandom;
    return r;
  endfunction

  // Drive this cycle's slave response, compare outputs, advance one cycle.
  task automatic playRec(input rec_t r);
    i_wb_ack = r.ack;
    i_wb_err = r.err;
    i_wb_dat = r.rdat;
    #1;
    checkOutput("stage",  32'(o_stage),      32'(r.stage));
    checkOutput("done",   32'(o_stage_done), 32'(r.done));
    checkOutput("cyc",    32'(o_wb_cyc),     32'(r.cyc));
    checkOutput("stb",    32'(o_wb_stb),     32'(r.cyc));
    checkOutput("halted", 32'(o_halted),     32'(r.halt));
    if (r.cyc) begin
      checkOutput("adr", o_wb_adr,       r.adr);
      checkOutput("sel", 32'(o_wb_sel),  32'(r.sel));
      checkOutput("we",  32'(o_wb_we),   32'(r.we));
      if (r.we) checkOutput("dat", o_wb_dat, r.dat);
    end
    if (r.stage == 3'd4) checkOutput("tcm_sel", 32'(o_tcm_data_sel), 32'(r.tsel));
    @(negedge i_clk);
  endtask

  task automatic playPlan(input int n);
    for (int i = 0; i < plan.size() && (n < 0 || i < n); i++) playRec(plan[i]);
  endtask

  task automatic checkCaptures();
    checkOutput("inst",       o_inst,            exp_inst);
    checkOutput("inst_wb",    32'(o_inst_wb),    32'(exp_inst_wb));
    checkOutput("rdata",      o_rdata,           exp_rdata);
    checkOutput("halted_st",  32'(o_halted),     32'(exp_halted));
    checkOutput("fault_addr", o_fault_addr,      exp_fault);
  endtask

  task automatic applyReset();
    i_reset_n   = 1'b0;
    i_wb_ack    = 1'b0;
    i_wb_err    = 1'b0;
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    checkOutput("rst_stage", 32'(o_stage),      32'd5);
    checkOutput("rst_done",  32'(o_stage_done), 32'd0);
    checkOutput("rst_cyc",   32'(o_wb_cyc),     32'd0);
    checkOutput("rst_stb",   32'(o_wb_stb),     32'd0);
    checkOutput("rst_we",    32'(o_wb_we),      32'd0);
    checkOutput("rst_sel",   32'(o_wb_sel),     32'd0);
    checkOutput("rst_adr",   o_wb_adr,          32'd0);
    checkOutput("rst_dat",   o_wb_dat,          32'd0);
    exp_inst = '0; exp_rdata = '0; exp_fault = '0; exp_inst_wb = 1'b0; exp_halted = 1'b0;
    checkCaptures();
    i_reset_n = 1'b1;
  endtask

  // mode: 0 = memory ACK on phase cycle m_n, 1 = ERR+ACK on first bus cycle,
  // 2 = silent slave (timeout).
  task automatic buildInstr(input logic [29:0] pc, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] sel, input int f_n, input int m_n, input int mode);
    rec_t        r;
    logic [31:0] d;
    int          last;
    i_pc = pc; i_mem_read = rd; i_mem_write = wr; i_addr = addr; i_wdata = wdata; i_sel = sel;
    plan.delete();
    plan.push_back(mk(3'd5, 5'b10000));
    if (pc[29:26] != 4'h0) begin
      d = $urandom;
      plan.push_back(mk(3'd1, 5'b0));
      for (int k = 2; k <= f_n; k++) begin
        r = mk(3'd1, (k == f_n) ? 5'b00001 : 5'b0);
        r.cyc = 1'b1; r.adr = {pc, 2'b00}; r.sel = 4'hF; r.we = 1'b0;
        if (k == f_n) begin r.ack = 1'b1; r.rdat = d; end
        plan.push_back(r);
      end
      exp_inst = d; exp_inst_wb = 1'b1;
    end else begin
      plan.push_back(mk(3'd1, 5'b00001));
      exp_inst_wb = 1'b0;
    end
    plan.push_back(mk(3'd2, 5'b00010));
    plan.push_back(mk(3'd3, 5'b00100));
    if (!(rd || wr) || addr[31:28] == 4'h0) begin
      r = mk(3'd4, 5'b01000);
      r.tsel = rd || wr;
      plan.push_back(r);
    end else begin
      d = $urandom;
      last = (mode == 1) ? 2 : (mode == 2) ? TB_TIMEOUT + 1 : m_n;
      plan.push_back(mk(3'd4, 5'b0));
      for (int k = 2; k <= last; k++) begin
        r = mk(3'd4, (mode == 0 && k == last) ? 5'b01000 : 5'b0);
        r.cyc = 1'b1; r.adr = addr; r.sel = sel; r.we = wr; r.dat = wdata;
        if (k == last && mode != 2) begin r.ack = 1'b1; r.err = (mode == 1); r.rdat = d; end
        plan.push_back(r);
      end
      if (mode == 0 && !wr) exp_rdata = d;
      if (mode != 0) begin
        r = mk(3'd7, 5'b0); r.halt = 1'b1;
        plan.push_back(r);
        plan.push_back(r);
        exp_halted = 1'b1; exp_fault = addr;
      end
    end
  endtask

  task automatic applyStimulus(input logic [29:0] pc, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] sel, input int f_n, input int m_n, input int mode);
    buildInstr(pc, rd, wr, addr, wdata, sel, f_n, m_n, mode);
    playPlan(-1);
    checkCaptures();
  endtask

  initial begin
    logic [29:0] pc;
    logic [31:0] addr;
    i_reset_n = 1'b0; i_pc = '0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_addr = '0; i_wdata = '0; i_sel = '0; i_wb_dat = '0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
    applyReset();

    $display("[TB] TCM-only sequence");
    applyStimulus(30'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 2, 2, 0);
    applyStimulus(30'h0000_0101, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 2, 2, 0);

    $display("[TB] WB fetch, ACK on fourth FETCH cycle");
    applyStimulus(30'h1000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 4, 2, 0);

    $display("[TB] WB store, immediate ACK");
    applyStimulus(30'h0000_0102, 1'b0, 1'b1, 32'h2000_0010, 32'hA5A5_1234, 4'b0011, 2, 2, 0);

    $display("[TB] WB load and read+write collision");
    applyStimulus(30'h0000_0103, 1'b1, 1'b0, 32'h6000_0008, 32'h0, 4'hF, 2, 3, 0);
    applyStimulus(30'h0000_0104, 1'b1, 1'b1, 32'h7000_0004, 32'h1357_9BDF, 4'hC, 2, 2, 0);

    $display("[TB] ERR with ACK on load");
    applyStimulus(30'h0000_0105, 1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 2, 2, 1);
    applyReset();

    $display("[TB] silent slave timeout");
    applyStimulus(30'h0000_0106, 1'b1, 1'b0, 32'h5000_0000, 32'h0, 4'hF, 2, 2, 2);
    applyReset();

    $display("[TB] ACK on the expiry cycle");
    applyStimulus(30'h0000_0107, 1'b1, 1'b0, 32'h5000_0004, 32'h0, 4'hF, 2, TB_TIMEOUT + 1, 0);

    $display("[TB] randomized instructions");
    for (int n = 0; n < 24; n++) begin
      pc   = 30'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) pc[29:26] = 4'h0;
      if ($urandom_range(0, 1) == 0) addr[31:28] = 4'h0;
      applyStimulus(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom,
                    4'($urandom), $urandom_range(2, TB_TIMEOUT + 1), $urandom_range(2, TB_TIMEOUT + 1), 0);
    end

    $display("[TB] reset during a WB fetch wait");
    buildInstr(30'h1000_0040, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 10, 2, 0);
    playPlan(4);
    i_reset_n = 1'b0;
    i_wb_ack  = 1'b1;
    i_wb_dat  = 32'hCAFE_F00D;
    @(negedge i_clk);
    #1;
    checkOutput("mid_cyc",    32'(o_wb_cyc),  32'd0);
    checkOutput("mid_stb",    32'(o_wb_stb),  32'd0);
    checkOutput("mid_stage",  32'(o_stage),   32'd5);
    checkOutput("mid_halted", 32'(o_halted),  32'd0);
    checkOutput("mid_inst",   o_inst,         32'd0);
    applyReset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
